// File: rtl/pulpemu_rst_pkg.sv
// Shared types and helpers for the emulation-top reset controller.
package pulpemu_rst_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_STRETCH,
    ST_RELEASE,
    ST_RUN
  } rst_state_e;

  // Width of a counter that must hold values 0..max_val (never narrower than 1 bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pulpemu_rst_debounce.sv
// One reset source: 2-FF synchroniser, polarity normalisation and a
// consecutive-sample debounce filter. req_o is active-high.
module pulpemu_rst_debounce
  import pulpemu_rst_pkg::*;
#(
  parameter bit          ACTIVE_HIGH     = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  output logic req_o
);

  localparam int unsigned CW       = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  // Synchroniser powers up at the asserted level so no spurious edge is seen.
  localparam logic [1:0]  SYNC_RST = ACTIVE_HIGH ? 2'b11 : 2'b00;

  logic [1:0]    sync;
  logic          sample;
  logic [CW-1:0] cnt;

  assign sample = ACTIVE_HIGH ? sync[1] : ~sync[1];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync  <= SYNC_RST;
      req_o <= 1'b1;
      cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep the two flops as a real 2-stage chain.
      sync <= {sync[0], req_i};
      if (sample == req_o) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        req_o <= sample;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/pulpemu_rst_ctrl.sv
// Reset controller for the FPGA emulation top: filtered reset sources,
// stretched request, ordered release of N_STAGES resets, sticky cause record.
module pulpemu_rst_ctrl
  import pulpemu_rst_pkg::*;
#(
  parameter int unsigned      N_SRC            = 2,
  parameter logic [N_SRC-1:0] SRC_ACTIVE_HIGH  = 2'b01,
  parameter int unsigned      N_STAGES         = 2,
  parameter int unsigned      DEBOUNCE_CYCLES  = 16,
  parameter int unsigned      STRETCH_CYCLES   = 64,
  parameter int unsigned      STAGE_GAP_CYCLES = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N_SRC-1:0]    rst_req_i,
  input  logic                sw_rst_req_i,
  input  logic                cause_clr_i,
  output logic [N_STAGES-1:0] rst_no,
  output logic [N_SRC:0]      rst_cause_o,
  output logic                busy_o
);

  localparam int unsigned CNT_MAX = (STRETCH_CYCLES > STAGE_GAP_CYCLES) ?
                                    STRETCH_CYCLES - 1 : STAGE_GAP_CYCLES - 1;
  localparam int unsigned CW = cnt_width(CNT_MAX);
  localparam int unsigned KW = cnt_width(N_STAGES - 1);

  localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(STAGE_GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [KW-1:0] K_LAST       = KW'(N_STAGES - 1);
  localparam logic [KW-1:0] K_ONE        = KW'(1);

  logic [N_SRC-1:0] filt;
  logic [N_SRC:0]   req_vec;
  logic             any_req;
  logic             capture;
  logic             booted;
  rst_state_e       state;
  logic [CW-1:0]    cnt;
  logic [KW-1:0]    k;
  logic [KW-1:0]    k_next;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    pulpemu_rst_debounce #(
      .ACTIVE_HIGH    (SRC_ACTIVE_HIGH[i]),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .req_i (rst_req_i[i]),
      .req_o (filt[i])
    );
  end

  assign req_vec = {sw_rst_req_i, filt};
  assign any_req = |req_vec;
  assign k_next  = k + K_ONE;
  // The power-on ASSERT episode is not a cause; once the block has left
  // ASSERT, requests held during later ASSERT episodes keep accumulating.
  assign capture = any_req && ((state != ST_ASSERT) || booted);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= ST_ASSERT;
      cnt         <= '0;
      k           <= '0;
      rst_no      <= '0;
      busy_o      <= 1'b1;
      rst_cause_o <= '0;
      booted      <= 1'b0;
    end else begin
      // A clear coinciding with a capture keeps only the newly captured bits.
      if (cause_clr_i) begin
        rst_cause_o <= capture ? req_vec : '0;
      end else if (capture) begin
        rst_cause_o <= rst_cause_o | req_vec;
      end

      if (state != ST_ASSERT) booted <= 1'b1;

      if (any_req) begin
        state  <= ST_ASSERT;
        cnt    <= '0;
        k      <= '0;
        rst_no <= '0;
        busy_o <= 1'b1;
      end else begin
        case (state)
          ST_ASSERT: begin
            state <= ST_STRETCH;
            cnt   <= '0;
          end
          ST_STRETCH: begin
            if (cnt == STRETCH_LAST) begin
              cnt <= '0;
              k   <= '0;
              if (N_STAGES == 1) begin
                state  <= ST_RUN;
                rst_no <= '1;
                busy_o <= 1'b0;
              end else begin
                state  <= ST_RELEASE;
                rst_no <= N_STAGES'(1);
              end
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          ST_RELEASE: begin
            if (cnt == GAP_LAST) begin
              cnt            <= '0;
              k              <= k_next;
              rst_no[k_next] <= 1'b1;
              if (k_next == K_LAST) begin
                state  <= ST_RUN;
                busy_o <= 1'b0;
              end
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          ST_RUN: state <= ST_RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulpemu_rst_ctrl.sv
// Directed bench for pulpemu_rst_ctrl with D=4, S=8, G=4, two sources
// (src0 active-high, src1 active-low) and two reset stages.
module tb_pulpemu_rst_ctrl;

  localparam logic [1:0] IDLE = 2'b10;  // both sources inactive
  localparam logic [1:0] SRC0 = 2'b11;  // src0 requesting
  localparam logic [1:0] SRC1 = 2'b00;  // src1 requesting

  typedef struct {
    int unsigned n;
    logic        rst_n;
    logic [1:0]  src;
    logic        sw;
    logic        clr;
    logic [1:0]  e_rst;
    logic        e_busy;
    logic [2:0]  e_cause;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] rst_req;
  logic       sw_rst_req;
  logic       cause_clr;
  logic [1:0] rst_no;
  logic [2:0] rst_cause;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;

  vec_t tbl [0:13];

  always #5 clk = ~clk;

  pulpemu_rst_ctrl #(
    .N_SRC           (2),
    .SRC_ACTIVE_HIGH (2'b01),
    .N_STAGES        (2),
    .DEBOUNCE_CYCLES (4),
    .STRETCH_CYCLES  (8),
    .STAGE_GAP_CYCLES(4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rst_req_i   (rst_req),
    .sw_rst_req_i(sw_rst_req),
    .cause_clr_i (cause_clr),
    .rst_no      (rst_no),
    .rst_cause_o (rst_cause),
    .busy_o      (busy)
  );

  function automatic vec_t mk(input int unsigned n, input logic r, input logic [1:0] src,
                              input logic sw, input logic clr, input logic [1:0] e_rst,
                              input logic e_busy, input logic [2:0] e_cause);
    vec_t v;
    v.n = n; v.rst_n = r; v.src = src; v.sw = sw; v.clr = clr;
    v.e_rst = e_rst; v.e_busy = e_busy; v.e_cause = e_cause;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs, advance n edges, then compare just after the last edge.
  task automatic apply(input string tag, input vec_t v);
    rst_n      = v.rst_n;
    rst_req    = v.src;
    sw_rst_req = v.sw;
    cause_clr  = v.clr;
    repeat (v.n) @(posedge clk);
    #1;
    check({tag, " rst_no"}, {6'b0, rst_no}, {6'b0, v.e_rst});
    check({tag, " busy"},   {7'b0, busy},   {7'b0, v.e_busy});
    check({tag, " cause"},  {5'b0, rst_cause}, {5'b0, v.e_cause});
  endtask

  initial begin
    rst_n = 1'b0; rst_req = IDLE; sw_rst_req = 1'b0; cause_clr = 1'b0;

    // Power-up: filters clear at edge 6, STRETCH 7..14, stage0 at 15, stage1 at 19.
    tbl[0]  = mk(3,  1'b0, IDLE, 1'b0, 1'b0, 2'b00, 1'b1, 3'b000);
    tbl[1]  = mk(14, 1'b1, IDLE, 1'b0, 1'b0, 2'b00, 1'b1, 3'b000);
    tbl[2]  = mk(1,  1'b1, IDLE, 1'b0, 1'b0, 2'b01, 1'b1, 3'b000);
    tbl[3]  = mk(3,  1'b1, IDLE, 1'b0, 1'b0, 2'b01, 1'b1, 3'b000);
    tbl[4]  = mk(1,  1'b1, IDLE, 1'b0, 1'b0, 2'b11, 1'b0, 3'b000);
    // Glitch of 3 cycles on src0 is filtered out.
    tbl[5]  = mk(3,  1'b1, SRC0, 1'b0, 1'b0, 2'b11, 1'b0, 3'b000);
    tbl[6]  = mk(10, 1'b1, IDLE, 1'b0, 1'b0, 2'b11, 1'b0, 3'b000);
    // Pad reset: still released after 6 edges, asserted after exactly 7.
    tbl[7]  = mk(6,  1'b1, SRC0, 1'b0, 1'b0, 2'b11, 1'b0, 3'b000);
    tbl[8]  = mk(1,  1'b1, SRC0, 1'b0, 1'b0, 2'b00, 1'b1, 3'b001);
    tbl[9]  = mk(13, 1'b1, SRC0, 1'b0, 1'b0, 2'b00, 1'b1, 3'b001);
    tbl[10] = mk(14, 1'b1, IDLE, 1'b0, 1'b0, 2'b00, 1'b1, 3'b001);
    tbl[11] = mk(1,  1'b1, IDLE, 1'b0, 1'b0, 2'b01, 1'b1, 3'b001);
    tbl[12] = mk(3,  1'b1, IDLE, 1'b0, 1'b0, 2'b01, 1'b1, 3'b001);
    tbl[13] = mk(1,  1'b1, IDLE, 1'b0, 1'b0, 2'b11, 1'b0, 3'b001);

    for (int i = 0; i < 14; i++) apply($sformatf("vec[%0d]", i), tbl[i]);

    // Abort mid-release: software pulse while only stage 0 is released.
    apply("clr_run",      mk(1, 1'b1, IDLE, 1'b0, 1'b1, 2'b11, 1'b0, 3'b000));
    apply("sw_start",     mk(1, 1'b1, IDLE, 1'b1, 1'b0, 2'b00, 1'b1, 3'b100));
    apply("sw_to_rel",    mk(9, 1'b1, IDLE, 1'b0, 1'b0, 2'b01, 1'b1, 3'b100));
    apply("clr_rel",      mk(1, 1'b1, IDLE, 1'b0, 1'b1, 2'b01, 1'b1, 3'b000));
    apply("abort_sw",     mk(1, 1'b1, IDLE, 1'b1, 1'b0, 2'b00, 1'b1, 3'b100));
    apply("restart_hold", mk(8, 1'b1, IDLE, 1'b0, 1'b0, 2'b00, 1'b1, 3'b100));
    apply("restart_st0",  mk(1, 1'b1, IDLE, 1'b0, 1'b0, 2'b01, 1'b1, 3'b100));
    apply("restart_run",  mk(4, 1'b1, IDLE, 1'b0, 1'b0, 2'b11, 1'b0, 3'b100));

    // Clear and set in the same cycle: only the new src1 bit survives.
    apply("src1_filter",  mk(6, 1'b1, SRC1, 1'b0, 1'b0, 2'b11, 1'b0, 3'b100));
    apply("clr_vs_set",   mk(1, 1'b1, SRC1, 1'b0, 1'b1, 2'b00, 1'b1, 3'b010));

    // Power-on reset taken while in STRETCH, then a clean power-up.
    apply("to_stretch",   mk(7, 1'b1, IDLE, 1'b0, 1'b0, 2'b00, 1'b1, 3'b010));
    apply("in_stretch",   mk(1, 1'b1, IDLE, 1'b0, 1'b0, 2'b00, 1'b1, 3'b010));
    apply("por_stretch",  mk(1, 1'b0, IDLE, 1'b0, 1'b0, 2'b00, 1'b1, 3'b000));
    apply("repower_st0",  mk(18, 1'b1, IDLE, 1'b0, 1'b0, 2'b01, 1'b1, 3'b000));
    apply("repower_run",  mk(1, 1'b1, IDLE, 1'b0, 1'b0, 2'b11, 1'b0, 3'b000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
